uart_rx: RTL and testbench

UART receiver for 8N1 serial frames: 1 start bit, 8 data bits LSB first, no parity, 1 stop bit. It oversamples the asynchronous `rx_serial` line at 16x the bit rate, using an external `baud_tick_16x` strobe from the shared baud generator. Each completed byte is presented on `rx_data` with a one-clock `rx_ready` pulse. Stop-bit failures are flagged on `rx_error`. The block sits between the pad/pin and the host-side RX buffer or FIFO.

---
 rtl/uart_rx.sv | 152 +++++++++++++++
 tb/tb_uart_rx.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// 8N1 UART receiver, 16x oversampled from an external baud strobe.
// Samples each bit at its centre and reports good bytes or framing errors as 1-clk pulses.
module uart_rx #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       baud_tick_16x,
  input  logic       rx_serial,
  output logic [7:0] rx_data,
  output logic       rx_ready,
  output logic       rx_error
);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

  logic [SYNC_STAGES-1:0] rx_sync;
  logic [SYNC_STAGES-1:0] tick_sync;
  logic                   tick_prev;
  logic                   rx_s;
  logic                   tick_s;
  logic                   tick_en;

  state_t     state_q, state_d;
  logic [3:0] tick_cnt_q, tick_cnt_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic       stop_seen_q, stop_seen_d;
  logic       stop_bit_q, stop_bit_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] data_d;
  logic       ready_d, error_d;

  // synchronizer stage: line presets to idle-high, tick to low
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_sync   <= '1;
      tick_sync <= '0;
      tick_prev <= 1'b0;
    end else begin
      rx_sync   <= {rx_sync[SYNC_STAGES-2:0], rx_serial};
      tick_sync <= {tick_sync[SYNC_STAGES-2:0], baud_tick_16x};
      tick_prev <= tick_s;
    end
  end

  assign rx_s    = rx_sync[SYNC_STAGES-1];
  assign tick_s  = tick_sync[SYNC_STAGES-1];
  assign tick_en = tick_s & ~tick_prev;

  // frame FSM: next-state and output decode
  always_comb begin
    state_d     = state_q;
    tick_cnt_d  = tick_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    stop_seen_d = stop_seen_q;
    stop_bit_d  = stop_bit_q;
    shift_d     = shift_q;
    data_d      = rx_data;
    ready_d     = 1'b0;
    error_d     = 1'b0;
    if (tick_en) begin
      case (state_q)
        IDLE: begin
          if (!rx_s) begin
            state_d    = START;
            tick_cnt_d = 4'd0;
          end
        end
        START: begin
          if (tick_cnt_q == 4'd7) begin
            tick_cnt_d = 4'd0;
            bit_cnt_d  = 3'd0;
            state_d    = rx_s ? IDLE : DATA;
          end else begin
            tick_cnt_d = tick_cnt_q + 4'd1;
          end
        end
        DATA: begin
          if (tick_cnt_q == 4'd15) begin
            shift_d    = {rx_s, shift_q[7:1]};
            tick_cnt_d = 4'd0;
            if (bit_cnt_q == 3'd7) begin
              state_d     = STOP;
              bit_cnt_d   = 3'd0;
              stop_seen_d = 1'b0;
            end else begin
              bit_cnt_d = bit_cnt_q + 3'd1;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 4'd1;
          end
        end
        STOP: begin
          // first phase finds the stop-bit centre, second waits out its back half
          if (!stop_seen_q) begin
            if (tick_cnt_q == 4'd15) begin
              stop_bit_d  = rx_s;
              stop_seen_d = 1'b1;
              tick_cnt_d  = 4'd0;
            end else begin
              tick_cnt_d = tick_cnt_q + 4'd1;
            end
          end else if (tick_cnt_q == 4'd7) begin
            tick_cnt_d  = 4'd0;
            stop_seen_d = 1'b0;
            if (stop_bit_q) begin
              data_d  = shift_q;
              ready_d = 1'b1;
              state_d = IDLE;
            end else begin
              error_d = 1'b1;
              state_d = WAIT_HIGH;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 4'd1;
          end
        end
        WAIT_HIGH: begin
          if (rx_s) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // control and output register stage
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      tick_cnt_q  <= 4'd0;
      bit_cnt_q   <= 3'd0;
      stop_seen_q <= 1'b0;
      rx_data     <= 8'h00;
      rx_ready    <= 1'b0;
      rx_error    <= 1'b0;
    end else begin
      state_q     <= state_d;
      tick_cnt_q  <= tick_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      stop_seen_q <= stop_seen_d;
      rx_data     <= data_d;
      rx_ready    <= ready_d;
      rx_error    <= error_d;
    end
  end

  always_ff @(posedge clk) begin
    shift_q    <= shift_d;
    stop_bit_q <= stop_bit_d;
  end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: stimulus queues expected pulses, a monitor checks them.
module tb_uart_rx;

  localparam int TICK_DIV = 8;
  localparam int BIT_CLKS = 16 * TICK_DIV;

  logic       clk;
  logic       rst;
  logic       baud_tick_16x;
  logic       rx_serial;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic       rx_error;

  typedef struct {
    logic       is_err;
    logic [7:0] data;
  } exp_t;

  exp_t       exp_q[$];
  int         checks = 0;
  int         errors = 0;
  logic [7:0] last_good = 8'h00;

  uart_rx #(.SYNC_STAGES(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .baud_tick_16x(baud_tick_16x),
    .rx_serial    (rx_serial),
    .rx_data      (rx_data),
    .rx_ready     (rx_ready),
    .rx_error     (rx_error)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    int cnt;
    cnt = 0;
    baud_tick_16x = 1'b0;
    forever begin
      @(posedge clk);
      cnt = (cnt + 1) % TICK_DIV;
      baud_tick_16x = (cnt == 0);
    end
  end

  // monitor: every pulse must match the oldest queued expectation
  always @(negedge clk) begin
    if (!rst && (rx_ready || rx_error)) begin
      exp_t e;
      checks++;
      if (rx_ready && rx_error) begin
        errors++;
        $display("FAIL both_pulses: rx_ready=%0b rx_error=%0b, required not both high", rx_ready, rx_error);
      end
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse: rx_ready=%0b rx_error=%0b rx_data=%02h, required no pulse",
                 rx_ready, rx_error, rx_data);
      end else begin
        e = exp_q.pop_front();
        if (rx_error !== e.is_err || rx_ready !== !e.is_err || rx_data !== e.data) begin
          errors++;
          $display("FAIL frame_result: ready=%0b err=%0b data=%02h, required ready=%0b err=%0b data=%02h",
                   rx_ready, rx_error, rx_data, !e.is_err, e.is_err, e.data);
        end
      end
    end
  end

  task automatic check_val(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %02h, required %02h", name, act, req);
    end
  endtask

  task automatic drain(input string name, input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s: %0d pulse(s) still outstanding after %0d clk, required 0", name, exp_q.size(), budget);
      exp_q.delete();
    end
  endtask

  task automatic drive_bit(input logic b, input int clks);
    rx_serial = b;
    repeat (clks) @(posedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_ok, input logic do_drain);
    exp_t e;
    e.is_err = !stop_ok;
    e.data   = stop_ok ? d : last_good;
    exp_q.push_back(e);
    if (stop_ok) last_good = d;
    drive_bit(1'b0, BIT_CLKS);
    for (int i = 0; i < 8; i++) drive_bit(d[i], BIT_CLKS);
    drive_bit(stop_ok, BIT_CLKS);
    if (!stop_ok) drive_bit(1'b0, 3 * BIT_CLKS);
    rx_serial = 1'b1;
    if (do_drain) drain($sformatf("pulse_%02h", d), 2 * 16 * TICK_DIV + 8);
  endtask

  initial begin
    rst = 1'b1;
    rx_serial = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check_val("reset_data", rx_data, 8'h00);
    check_val("reset_ready", {7'd0, rx_ready}, 8'h00);
    check_val("reset_error", {7'd0, rx_error}, 8'h00);
    @(posedge clk);
    rst = 1'b0;
    repeat (40) @(posedge clk);

    send_frame(8'h41, 1'b1, 1'b1);
    check_val("data_41", rx_data, 8'h41);

    repeat (100) @(posedge clk);
    send_frame(8'h42, 1'b1, 1'b1);
    check_val("data_42", rx_data, 8'h42);
    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b1);
    check_val("data_ff", rx_data, 8'hFF);

    repeat (BIT_CLKS) @(posedge clk);
    send_frame(8'h5A, 1'b0, 1'b1);
    check_val("data_kept", rx_data, 8'hFF);
    repeat (BIT_CLKS) @(posedge clk);
    send_frame(8'h3C, 1'b1, 1'b1);
    check_val("data_3c", rx_data, 8'h3C);

    repeat (BIT_CLKS) @(posedge clk);
    drive_bit(1'b0, 4 * TICK_DIV);
    drive_bit(1'b1, 2 * BIT_CLKS);
    check_val("glitch_data", rx_data, 8'h3C);
    send_frame(8'hA5, 1'b1, 1'b1);
    check_val("data_a5", rx_data, 8'hA5);

    repeat (BIT_CLKS) @(posedge clk);
    drive_bit(1'b0, BIT_CLKS);
    for (int i = 0; i < 4; i++) drive_bit(i[0], BIT_CLKS);
    drive_bit(1'b1, BIT_CLKS / 2);
    rst = 1'b1;
    rx_serial = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check_val("midrst_data", rx_data, 8'h00);
    check_val("midrst_ready", {7'd0, rx_ready}, 8'h00);
    check_val("midrst_error", {7'd0, rx_error}, 8'h00);
    @(posedge clk);
    rst = 1'b0;
    last_good = 8'h00;
    repeat (2 * BIT_CLKS) @(posedge clk);
    send_frame(8'h81, 1'b1, 1'b1);
    check_val("data_81", rx_data, 8'h81);

    repeat (2 * BIT_CLKS) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL final_queue: %0d outstanding, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
